stream_header_inserter: RTL and testbench

- Avalon-ST packet block that prepends a runtime-selectable header of 0..MAX_HDR_BEATS beats to every packet, MSB-first.
- Generalised successor of the fixed-header adder, with three additions: full valid/ready back-pressure on both sides, per-packet header length, and a zero-length bypass mode.
- Sits in the AES datapath ahead of framing/egress. Header and length are sampled once per packet at SOP.
- Counts packets inserted and orphan beats dropped.

---
 rtl/hdr_ins_pkg.sv | 20 ++
 rtl/avalon_st_if.sv | 18 +
 rtl/hdr_beat_mux.sv | 21 ++
 rtl/stream_header_inserter.sv | 141 ++++++++++++++
 tb/tb_stream_header_inserter.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hdr_ins_pkg.sv
// Shared types and width helpers for the stream header inserter.
package hdr_ins_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HEADER   = 2'd1,
    DATA     = 2'd2,
    DATA_BYP = 2'd3
  } state_t;

  // Width of a field able to hold 0..max_beats inclusive.
  function automatic int len_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

  function automatic int empty_width(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST packet stream bundle shared by producers and consumers.
// A beat transfers on a rising clk edge where valid & ready are both high; once valid
// is raised the master holds every field stable until that transfer, and valid never
// waits on ready.
interface avalon_st_if #(
  parameter int DATA_WIDTH  = 128,
  parameter int EMPTY_WIDTH = hdr_ins_pkg::empty_width(DATA_WIDTH)
);
  logic                   valid;
  logic                   ready;
  logic                   sop;
  logic                   eop;
  logic [EMPTY_WIDTH-1:0] empty;
  logic [DATA_WIDTH-1:0]  data;

  modport master (output valid, sop, eop, empty, data, input ready);
  modport slave  (input valid, sop, eop, empty, data, output ready);
endinterface

// File: rtl/hdr_beat_mux.sv
// Combinational selector of one header beat; beat 0 is the most significant slice.
module hdr_beat_mux #(
  parameter int DATA_WIDTH    = 128,
  parameter int MAX_HDR_BEATS = 4,
  parameter int IDX_WIDTH     = $clog2(MAX_HDR_BEATS + 1)
) (
  input  logic [MAX_HDR_BEATS*DATA_WIDTH-1:0] hdr,
  input  logic [IDX_WIDTH-1:0]                idx,
  output logic [DATA_WIDTH-1:0]               beat
);

  always_comb begin
    beat = '0;
    for (int i = 0; i < MAX_HDR_BEATS; i++) begin
      if (idx == IDX_WIDTH'(i)) begin
        beat = hdr[(MAX_HDR_BEATS-1-i)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/stream_header_inserter.sv
// Prepends a per-packet header of 0..MAX_HDR_BEATS beats to each Avalon-ST packet,
// with full back-pressure, a zero-length bypass path and packet/drop statistics.
module stream_header_inserter
  import hdr_ins_pkg::*;
#(
  parameter int DATA_WIDTH    = 128,
  parameter int MAX_HDR_BEATS = 4,
  parameter int EMPTY_WIDTH   = empty_width(DATA_WIDTH),
  parameter int CNT_WIDTH     = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  avalon_st_if.slave                          data_in,
  avalon_st_if.master                         data_out,
  input  logic [MAX_HDR_BEATS*DATA_WIDTH-1:0] header_data,
  input  logic [len_width(MAX_HDR_BEATS)-1:0] hdr_beats,
  output logic [CNT_WIDTH-1:0]                pkt_cnt,
  output logic [CNT_WIDTH-1:0]                drop_cnt,
  output state_t                              state
);

  localparam int                   LEN_WIDTH = len_width(MAX_HDR_BEATS);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN   = LEN_WIDTH'(MAX_HDR_BEATS);

  state_t                              state_next;
  logic [LEN_WIDTH-1:0]                cnt;
  logic [LEN_WIDTH-1:0]                hdr_len;
  logic [LEN_WIDTH-1:0]                hdr_len_in;
  logic [MAX_HDR_BEATS*DATA_WIDTH-1:0] hdr_reg;
  logic [DATA_WIDTH-1:0]               hdr_beat;
  logic                                ready_en;

  logic                   out_valid;
  logic                   out_sop;
  logic                   out_eop;
  logic [EMPTY_WIDTH-1:0] out_empty;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   in_ready;
  logic                   in_hs;
  logic                   out_hs;
  logic                   hdr_last;
  logic                   idle_capture;
  logic                   drop_beat;
  logic                   pkt_done;

  hdr_beat_mux #(
    .DATA_WIDTH   (DATA_WIDTH),
    .MAX_HDR_BEATS(MAX_HDR_BEATS),
    .IDX_WIDTH    (LEN_WIDTH)
  ) u_hdr_beat_mux (
    .hdr (hdr_reg),
    .idx (cnt),
    .beat(hdr_beat)
  );

  assign hdr_len_in = (hdr_beats > MAX_LEN) ? MAX_LEN : hdr_beats;
  assign hdr_last   = (cnt == hdr_len - LEN_WIDTH'(1));

  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_sop      = 1'b0;
    out_eop      = 1'b0;
    out_empty    = '0;
    out_data     = '0;
    idle_capture = 1'b0;
    drop_beat    = 1'b0;
    pkt_done     = 1'b0;
    case (state)
      IDLE: begin
        // ready_en keeps the input stalled until the first edge after reset release.
        in_ready  = ready_en & ~data_in.sop;
        drop_beat = data_in.valid & in_ready;
        if (ready_en && data_in.valid && data_in.sop) begin
          idle_capture = 1'b1;
          state_next   = (hdr_len_in != '0) ? HEADER : DATA_BYP;
        end
      end
      HEADER: begin
        out_valid = 1'b1;
        out_data  = hdr_beat;
        out_sop   = (cnt == '0);
        if (data_out.ready && hdr_last) begin
          state_next = DATA;
        end
      end
      DATA, DATA_BYP: begin
        out_valid = data_in.valid;
        in_ready  = data_out.ready;
        out_data  = data_in.data;
        out_eop   = data_in.eop;
        out_empty = data_in.eop ? data_in.empty : '0;
        // In bypass cnt flags whether the first beat has gone, so only the real SOP passes.
        out_sop   = (state == DATA_BYP) && (cnt == '0) && data_in.sop;
        if (data_in.valid && data_out.ready && data_in.eop) begin
          pkt_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_hs  = data_in.valid & in_ready;
  assign out_hs = out_valid & data_out.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      hdr_len  <= '0;
      hdr_reg  <= '0;
      ready_en <= 1'b0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
      if (idle_capture) begin
        hdr_len <= hdr_len_in;
        hdr_reg <= header_data;
        cnt     <= '0;
      end else if (state == HEADER && out_hs && !hdr_last) begin
        cnt <= cnt + LEN_WIDTH'(1);
      end else if (state == DATA_BYP && in_hs) begin
        cnt <= LEN_WIDTH'(1);
      end
      if (drop_beat) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      if (pkt_done)  pkt_cnt  <= pkt_cnt + CNT_WIDTH'(1);
    end
  end

  assign data_out.valid = out_valid;
  assign data_out.sop   = out_sop;
  assign data_out.eop   = out_eop;
  assign data_out.empty = out_empty;
  assign data_out.data  = out_data;
  assign data_in.ready  = in_ready;

endmodule

// File: tb/tb_stream_header_inserter.sv
// Randomised scoreboard bench for stream_header_inserter (32-bit beats, 4-beat header).
module tb_stream_header_inserter;
  import hdr_ins_pkg::*;

  localparam int DW    = 32;
  localparam int MAXB  = 4;
  localparam int EW    = 2;
  localparam int CW    = 32;
  localparam int LW    = 3;
  localparam int EXP_W = 3 + EW + DW;  // {is_hdr, sop, eop, empty, data}

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  avalon_st_if #(.DATA_WIDTH(DW)) in_if ();
  avalon_st_if #(.DATA_WIDTH(DW)) out_if ();

  logic [MAXB*DW-1:0] header_data;
  logic [LW-1:0]      hdr_beats;
  logic [CW-1:0]      pkt_cnt;
  logic [CW-1:0]      drop_cnt;
  state_t             state;

  stream_header_inserter #(
    .DATA_WIDTH   (DW),
    .MAX_HDR_BEATS(MAXB),
    .EMPTY_WIDTH  (EW),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (in_if),
    .data_out   (out_if),
    .header_data(header_data),
    .hdr_beats  (hdr_beats),
    .pkt_cnt    (pkt_cnt),
    .drop_cnt   (drop_cnt),
    .state      (state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int               tests = 0;
  int               fails = 0;
  int               exp_pkt = 0;
  int               exp_drop = 0;
  bit               mon_en = 1'b0;
  int               rdy_mode = 0;
  logic [DW-1:0]    pkt_data[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- output ready generator ----------------
  initial begin
    out_if.ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_if.ready = 1'b1;
        1:       out_if.ready = ~out_if.ready;
        default: out_if.ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [EXP_W-1:0] cur;
    logic [EXP_W-1:0] prev_beat;
    logic [EXP_W-1:0] e;
    bit               prev_stall;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_stall = 1'b0;
      end else begin
        cur = {1'b0, out_if.sop, out_if.eop, out_if.empty, out_if.data};
        if (prev_stall) begin
          check("hold_valid", 64'(out_if.valid), 64'(1));
          check("hold_beat", 64'(cur), 64'(prev_beat));
        end
        if (out_if.valid) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got %0h, expected no beat (t=%0t)", cur, $time);
          end else begin
            if (exp_q[0][EXP_W-1]) check("in_ready_hdr", 64'(in_if.ready), 64'(0));
            if (out_if.ready) begin
              e = exp_q.pop_front();
              e[EXP_W-1] = 1'b0;
              check("out_beat", 64'(cur), 64'(e));
            end
          end
        end
        prev_stall = out_if.valid & ~out_if.ready;
        prev_beat  = cur;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Waits for the current input beat to be accepted; returns 0 on timeout.
  task automatic wait_accept(input bit scramble, output bit ok);
    int t;
    t  = 0;
    ok = 1'b1;
    forever begin
      @(negedge clk);
      if (scramble && state != IDLE) begin
        header_data = {$urandom, $urandom, $urandom, $urandom};
        hdr_beats   = LW'($urandom_range(0, 7));
      end
      if (in_if.ready) break;
      t++;
      if (t > 1000) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: input beat not accepted after %0d cycles", t);
        ok = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Reference model: header beats (clamped to MAXB), then payload framed by first/last beat.
  task automatic send_packet(input int hb, input logic [MAXB*DW-1:0] hdr, input int n,
                             input int emp, input bit err_sop, input bit gaps);
    int hl;
    bit ok;
    hl = (hb > MAXB) ? MAXB : hb;
    for (int i = 0; i < hl; i++)
      exp_q.push_back({1'b1, (i == 0), 1'b0, EW'(0), hdr[MAXB*DW-1-i*DW -: DW]});
    for (int j = 0; j < n; j++)
      exp_q.push_back({1'b0, (hl == 0 && j == 0), (j == n-1),
                       (j == n-1) ? EW'(emp) : EW'(0), pkt_data[j]});
    header_data = hdr;
    hdr_beats   = LW'(hb);
    for (int j = 0; j < n; j++) begin
      in_if.valid = 1'b1;
      in_if.sop   = (j == 0) || (err_sop && j == 1);
      in_if.eop   = (j == n-1);
      in_if.empty = (j == n-1) ? EW'(emp) : EW'($urandom_range(0, 3));
      in_if.data  = pkt_data[j];
      wait_accept(j == 0, ok);
      if (!ok) begin
        in_if.valid = 1'b0;
        return;
      end
      in_if.valid = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    exp_pkt++;
    check("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
  endtask

  task automatic send_orphans(input int k);
    bit ok;
    for (int i = 0; i < k; i++) begin
      in_if.valid = 1'b1;
      in_if.sop   = 1'b0;
      in_if.eop   = 1'($urandom_range(0, 1));
      in_if.empty = EW'($urandom_range(0, 3));
      in_if.data  = $urandom;
      wait_accept(1'b0, ok);
      in_if.valid = 1'b0;
      if (!ok) return;
      exp_drop++;
    end
    check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
  endtask

  task automatic random_payload(input int n);
    for (int j = 0; j < n; j++) pkt_data[j] = $urandom;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  n;
    int  t;
    bit  seen;
    header_data  = '0;
    hdr_beats    = '0;
    in_if.valid  = 1'b0;
    in_if.sop    = 1'b0;
    in_if.eop    = 1'b0;
    in_if.empty  = '0;
    in_if.data   = '0;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_if.valid), 64'(0));
    check("rst_in_ready", 64'(in_if.ready), 64'(0));
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
    check("rst_drop_cnt", 64'(drop_cnt), 64'(0));
    check("rst_state", 64'(state), 64'(IDLE));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // 2-beat header, 3-beat packet, ready always high
    rdy_mode = 0;
    pkt_data[0] = 32'hD000_0000;
    pkt_data[1] = 32'hD111_1111;
    pkt_data[2] = 32'hD222_2222;
    send_packet(2, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, 3, 1, 1'b0, 1'b0);

    // same packet with toggling output ready
    rdy_mode = 1;
    send_packet(2, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, 3, 1, 1'b0, 1'b0);

    // bypass, single-beat packet
    rdy_mode = 0;
    pkt_data[0] = 32'h1234_5678;
    send_packet(0, {$urandom, $urandom, $urandom, $urandom}, 1, 3, 1'b0, 1'b0);
    check("byp_state_idle", 64'(state), 64'(IDLE));

    // oversize header request clamps to MAXB beats
    random_payload(2);
    send_packet(7, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 2, 2, 1'b0, 1'b0);

    // orphan beats in IDLE, then a good packet
    send_orphans(3);
    random_payload(4);
    send_packet(1, {$urandom, $urandom, $urandom, $urandom}, 4, 0, 1'b0, 1'b0);

    // reset during the second header beat
    mon_en = 1'b0;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    header_data = {$urandom, $urandom, $urandom, $urandom};
    hdr_beats   = LW'(3);
    in_if.valid = 1'b1;
    in_if.sop   = 1'b1;
    in_if.eop   = 1'b1;
    in_if.data  = $urandom;
    seen = 1'b0;
    t = 0;
    while (!seen && t < 50) begin
      @(negedge clk);
      seen = out_if.valid && out_if.sop && out_if.ready;
      t++;
    end
    check("rst_test_first_hdr_seen", 64'(seen), 64'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_if.valid), 64'(0));
    check("midrst_pkt_cnt", 64'(pkt_cnt), 64'(0));
    check("midrst_drop_cnt", 64'(drop_cnt), 64'(0));
    check("midrst_state", 64'(state), 64'(IDLE));
    in_if.valid = 1'b0;
    in_if.sop   = 1'b0;
    in_if.eop   = 1'b0;
    exp_q.delete();
    exp_pkt  = 0;
    exp_drop = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    random_payload(3);
    send_packet(2, {$urandom, $urandom, $urandom, $urandom}, 3, 1, 1'b0, 1'b0);

    // randomised traffic
    rdy_mode = 2;
    for (int p = 0; p < 150; p++) begin
      if ($urandom_range(0, 7) == 0) send_orphans($urandom_range(1, 3));
      n = $urandom_range(1, 8);
      random_payload(n);
      send_packet($urandom_range(0, 7), {$urandom, $urandom, $urandom, $urandom}, n,
                  $urandom_range(0, 3), ($urandom_range(0, 7) == 0), 1'b1);
    end

    // drain and final counters
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    check("final_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
    check("final_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    check("final_state", 64'(state), 64'(IDLE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
